// File: rtl/main_memory_pkg.sv
// Shared types and constants for the main_memory latency-modelling memory.
package main_memory_pkg;

  localparam int unsigned WordWidth      = 32;
  localparam int unsigned DefaultLatency = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/main_memory_array.sv
// Single-port word storage: synchronous write, combinational read on one shared address.
module main_memory_array #(
  parameter int unsigned Depth = 4096,
  parameter int unsigned Width = 32,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/main_memory.sv
// Fixed-latency memory model with a ready handshake and a shared bidirectional data bus.
// Optional MAIN_MEMORY_ALIGN_CHECK_EN adds misaligned_err and suppresses misaligned writes.
module main_memory
  import main_memory_pkg::*;
#(
  parameter int unsigned LATENCY     = DefaultLatency,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 read_Mem,
  input  logic                 write_Mem,
  input  logic [31:0]          Addr_Mem,
  inout  wire  [WordWidth-1:0] Data_Mem,
  output logic                 ready_mem
`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
  ,
  output logic                 misaligned_err
`endif
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [IdxW-1:0]      addr_q, addr_d;
  logic                 is_write_q, is_write_d;
  // Holds the write data for a write, then the fetched word for a read.
  logic [WordWidth-1:0] data_q, data_d;
  logic                 commit;
  logic                 array_we;
  logic [WordWidth-1:0] array_rdata;
  logic                 bus_drive;
  logic                 req;

  assign req = read_Mem | write_Mem;

`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
  logic unused_addr;
  assign unused_addr = ^Addr_Mem[31:IdxW+2];
`else
  logic unused_addr;
  assign unused_addr = ^{Addr_Mem[31:IdxW+2], Addr_Mem[1:0]};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    is_write_d = is_write_q;
    data_d     = data_q;
    commit     = 1'b0;
`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
    misaligned_d = misaligned_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d    = StBusy;
          addr_d     = Addr_Mem[IdxW+1:2];
          is_write_d = write_Mem;
          cnt_d      = 8'(LATENCY - 1);
          if (write_Mem) begin
            data_d = Data_Mem;
          end
`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
          misaligned_d = |Addr_Mem[1:0];
`endif
        end
      end
      StBusy: begin
        if (cnt_q == 8'd0) begin
          state_d = StDone;
          commit  = is_write_q;
          if (!is_write_q) begin
            data_d = array_rdata;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone: begin
        if (!req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  // Datapath registers only matter once a request has been accepted.
  always_ff @(posedge clk) begin
    addr_q     <= addr_d;
    is_write_q <= is_write_d;
    data_q     <= data_d;
  end

  // Gating with rst_n keeps a reset on the commit edge from writing the array.
`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
  assign array_we       = commit & rst_n & ~misaligned_q;
  assign misaligned_err = misaligned_q;
`else
  assign array_we = commit & rst_n;
`endif

  main_memory_array #(
    .Depth(DEPTH_WORDS),
    .Width(WordWidth),
    .AddrW(IdxW)
  ) u_array (
    .clk_i  (clk),
    .we_i   (array_we),
    .addr_i (addr_q),
    .wdata_i(data_q),
    .rdata_o(array_rdata)
  );

  assign ready_mem = (state_q != StBusy);
  assign bus_drive = (state_q == StDone) & ~is_write_q & read_Mem;
  assign Data_Mem  = bus_drive ? data_q : {WordWidth{1'bz}};

endmodule
